// File: rtl/maze_cursor_ctrl.sv
// ---------------------------------------------------------------------------
// maze_cursor_ctrl
//   Moves a cursor around a MAZE_W x MAZE_H grid of cells, one move per
//   step_en tick while run is high. Cells are numbered row-major
//   (cell = row*MAZE_W + col). Hitting a wall or the grid edge either crashes
//   the cursor (WALL_MODE=0) or blocks the move (WALL_MODE=1). Reaching
//   goal_spot wins. From CRASH or WIN, CTRLbtn respawns at begin_spot.
//
// Ports
//   CLK, RST        clock, asynchronous active-high reset
//   step_en         one-CLK move tick
//   run             1 = play, 0 = paused (everything holds)
//   UPbtn..LEFTbtn  direction buttons, priority UP > DOWN > RIGHT > LEFT
//   CTRLbtn         respawn request (only honoured in CRASH / WIN)
//   mazestate       bit i = 1 means cell i is open
//   begin_spot      respawn cell
//   goal_spot       goal cell
//   pos             current cell, all-ones while crashed
//   state           00 PLAY, 01 CRASH, 10 WIN
//   moved, bumped   one-CLK pulses for accepted / blocked moves
//   move_count      accepted moves since last (re)spawn, saturating
// ---------------------------------------------------------------------------
module maze_cursor_ctrl #(
  parameter int MAZE_W    = 18,
  parameter int MAZE_H    = 11,
  parameter int POS_W     = 8,
  parameter int START_POS = 181,
  parameter int WALL_MODE = 0,
  parameter int CNT_W     = 10
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      step_en,
  input  logic                      run,
  input  logic                      UPbtn,
  input  logic                      DOWNbtn,
  input  logic                      RIGHTbtn,
  input  logic                      LEFTbtn,
  input  logic                      CTRLbtn,
  input  logic [MAZE_W*MAZE_H-1:0]  mazestate,
  input  logic [POS_W-1:0]          begin_spot,
  input  logic [POS_W-1:0]          goal_spot,
  output logic [POS_W-1:0]          pos,
  output logic [1:0]                state,
  output logic                      moved,
  output logic                      bumped,
  output logic [CNT_W-1:0]          move_count
);

  localparam int CELLS = MAZE_W * MAZE_H;
  localparam logic [POS_W-1:0] SENTINEL = '1;

  typedef enum logic [1:0] {
    S_PLAY  = 2'b00,
    S_CRASH = 2'b01,
    S_WIN   = 2'b10,
    S_BAD   = 2'b11
  } state_t;

  state_t            state_q, state_n;
  logic [POS_W-1:0]  pos_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              moved_n, bumped_n;

  int   pos_i, row_i, col_i, cand_i, begin_i;
  logic dir_any, edge_hit, legal, begin_ok;

  // Cell lookup by shifting rather than indexing, so the index can be a
  // plain integer; callers guarantee idx is inside the grid.
  function automatic logic cell_open(input logic [CELLS-1:0] maze, input int idx);
    logic [CELLS-1:0] sh;
    sh = maze >> idx;
    return sh[0];
  endfunction

  // Candidate cell for the highest-priority pressed direction. Edge checks
  // are done on row/column of the registered pos so a move never wraps.
  always_comb begin
    pos_i    = int'(pos);
    row_i    = pos_i / MAZE_W;
    col_i    = pos_i % MAZE_W;
    cand_i   = 0;
    dir_any  = 1'b1;
    edge_hit = 1'b0;
    if (UPbtn) begin
      edge_hit = (row_i == 0);
      cand_i   = pos_i - MAZE_W;
    end else if (DOWNbtn) begin
      edge_hit = (row_i == MAZE_H - 1);
      cand_i   = pos_i + MAZE_W;
    end else if (RIGHTbtn) begin
      edge_hit = (col_i == MAZE_W - 1);
      cand_i   = pos_i + 1;
    end else if (LEFTbtn) begin
      edge_hit = (col_i == 0);
      cand_i   = pos_i - 1;
    end else begin
      dir_any  = 1'b0;
    end
    legal = 1'b0;
    if (!edge_hit && pos_i < CELLS)
      legal = cell_open(mazestate, cand_i);

    begin_i  = int'(begin_spot);
    begin_ok = 1'b0;
    if (begin_i < CELLS)
      begin_ok = cell_open(mazestate, begin_i);
  end

  // Next-state logic. Nothing changes outside an enabled tick; in CRASH/WIN
  // the direction buttons are ignored, so CTRLbtn always wins over them.
  always_comb begin
    state_n  = state_q;
    pos_n    = pos;
    cnt_n    = move_count;
    moved_n  = 1'b0;
    bumped_n = 1'b0;
    if (step_en && run) begin
      case (state_q)
        S_PLAY: begin
          if (dir_any) begin
            if (legal) begin
              pos_n   = POS_W'(cand_i);
              moved_n = 1'b1;
              if (move_count != '1)
                cnt_n = move_count + CNT_W'(1);
              if (POS_W'(cand_i) == goal_spot)
                state_n = S_WIN;
            end else if (WALL_MODE == 0) begin
              state_n = S_CRASH;
              pos_n   = SENTINEL;
            end else begin
              bumped_n = 1'b1;
            end
          end
        end
        S_CRASH, S_WIN: begin
          if (CTRLbtn) begin
            if (begin_ok) begin
              state_n = S_PLAY;
              pos_n   = begin_spot;
              cnt_n   = '0;
            end else begin
              state_n = S_CRASH;
              pos_n   = SENTINEL;
            end
          end
        end
        default: begin
          state_n = S_CRASH;
          pos_n   = SENTINEL;
        end
      endcase
    end
  end

  // State register with asynchronous reset to the start cell.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_PLAY;
      pos        <= POS_W'(START_POS);
      move_count <= '0;
      moved      <= 1'b0;
      bumped     <= 1'b0;
    end else begin
      state_q    <= state_n;
      pos        <= pos_n;
      move_count <= cnt_n;
      moved      <= moved_n;
      bumped     <= bumped_n;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_maze_cursor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_maze_cursor_ctrl
//   Two instances share all inputs: dut0 crashes on walls (WALL_MODE=0,
//   CNT_W=10), dut1 blocks on walls (WALL_MODE=1, CNT_W=4 so saturation is
//   reachable). A grid-coordinate reference model predicts each tick's result
//   and queues it; a monitor pops and compares after every rising edge.
// ---------------------------------------------------------------------------
module tb_maze_cursor_ctrl;

  localparam int W     = 18;
  localparam int H     = 11;
  localparam int CELLS = W * H;

  typedef struct packed {
    logic [7:0] pos;
    logic [1:0] st;
    logic       moved;
    logic       bumped;
    logic [9:0] cnt;
  } exp_t;

  localparam exp_t RST_EXP = '{pos: 8'd181, st: 2'd0, moved: 1'b0, bumped: 1'b0, cnt: 10'd0};
  localparam logic [4:0] B_UP = 5'b10000;
  localparam logic [4:0] B_DN = 5'b01000;
  localparam logic [4:0] B_RT = 5'b00100;
  localparam logic [4:0] B_LT = 5'b00010;
  localparam logic [4:0] B_CT = 5'b00001;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             step_en = 1'b0, run = 1'b0;
  logic             UPbtn = 1'b0, DOWNbtn = 1'b0, RIGHTbtn = 1'b0, LEFTbtn = 1'b0, CTRLbtn = 1'b0;
  logic [CELLS-1:0] mazestate = '1;
  logic [7:0]       begin_spot = 8'd0, goal_spot = 8'd197;

  logic [7:0] pos0, pos1;
  logic [1:0] state0, state1;
  logic       moved0, moved1, bumped0, bumped1;
  logic [9:0] cnt0;
  logic [3:0] cnt1;

  // Staged stimulus, copied onto the DUT inputs only at the falling edge.
  logic [CELLS-1:0] s_maze = '1;
  logic [7:0]       s_begin = 8'd0, s_goal = 8'd197;

  int m_pos [2];
  int m_st  [2];
  int m_cnt [2];

  exp_t q0[$];
  exp_t q1[$];

  int n_vec  = 0;
  int n_miss = 0;

  maze_cursor_ctrl #(.WALL_MODE(0), .CNT_W(10)) dut0 (
    .CLK(CLK), .RST(RST), .step_en(step_en), .run(run),
    .UPbtn(UPbtn), .DOWNbtn(DOWNbtn), .RIGHTbtn(RIGHTbtn), .LEFTbtn(LEFTbtn), .CTRLbtn(CTRLbtn),
    .mazestate(mazestate), .begin_spot(begin_spot), .goal_spot(goal_spot),
    .pos(pos0), .state(state0), .moved(moved0), .bumped(bumped0), .move_count(cnt0));

  maze_cursor_ctrl #(.WALL_MODE(1), .CNT_W(4)) dut1 (
    .CLK(CLK), .RST(RST), .step_en(step_en), .run(run),
    .UPbtn(UPbtn), .DOWNbtn(DOWNbtn), .RIGHTbtn(RIGHTbtn), .LEFTbtn(LEFTbtn), .CTRLbtn(CTRLbtn),
    .mazestate(mazestate), .begin_spot(begin_spot), .goal_spot(goal_spot),
    .pos(pos1), .state(state1), .moved(moved1), .bumped(bumped1), .move_count(cnt1));

  always #5 CLK = ~CLK;

  function automatic exp_t act0();
    return '{pos: pos0, st: state0, moved: moved0, bumped: bumped0, cnt: cnt0};
  endfunction

  function automatic exp_t act1();
    return '{pos: pos1, st: state1, moved: moved1, bumped: bumped1, cnt: {6'd0, cnt1}};
  endfunction

  function automatic bit open_cell(input int i);
    logic [CELLS-1:0] t;
    t = mazestate >> i;
    return t[0];
  endfunction

  task automatic checkOutput(input string name, input exp_t want, input exp_t got);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("[TB] FAIL %s: got pos=%0d st=%0d moved=%0d bumped=%0d cnt=%0d, expected pos=%0d st=%0d moved=%0d bumped=%0d cnt=%0d",
               name, got.pos, got.st, got.moved, got.bumped, got.cnt,
               want.pos, want.st, want.moved, want.bumped, want.cnt);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = 181;
      m_st[k]  = 0;
      m_cnt[k] = 0;
    end
  endtask

  // Reference behaviour in grid coordinates: step by (dr,dc), reject if the
  // new coordinate is outside the grid or a wall.
  task automatic model_tick(input int k, input int wall_mode, input int cnt_max, output exp_t e);
    int  r, c, dr, dc, nr, nc;
    bit  any, mv, bp;
    mv = 0;
    bp = 0;
    if (step_en && run) begin
      if (m_st[k] == 0) begin
        any = 1;
        dr  = 0;
        dc  = 0;
        if (UPbtn)         dr = -1;
        else if (DOWNbtn)  dr = 1;
        else if (RIGHTbtn) dc = 1;
        else if (LEFTbtn)  dc = -1;
        else               any = 0;
        if (any) begin
          r  = m_pos[k] / W;
          c  = m_pos[k] % W;
          nr = r + dr;
          nc = c + dc;
          if (nr < 0 || nr >= H || nc < 0 || nc >= W || !open_cell(nr * W + nc)) begin
            if (wall_mode == 0) begin
              m_st[k]  = 1;
              m_pos[k] = 255;
            end else begin
              bp = 1;
            end
          end else begin
            m_pos[k] = nr * W + nc;
            mv = 1;
            if (m_cnt[k] < cnt_max) m_cnt[k]++;
            if (m_pos[k] == int'(goal_spot)) m_st[k] = 2;
          end
        end
      end else if (CTRLbtn) begin
        if (int'(begin_spot) < CELLS && open_cell(int'(begin_spot))) begin
          m_pos[k] = int'(begin_spot);
          m_cnt[k] = 0;
          m_st[k]  = 0;
        end else begin
          m_st[k]  = 1;
          m_pos[k] = 255;
        end
      end
    end
    e = '{pos: 8'(m_pos[k]), st: 2'(m_st[k]), moved: mv, bumped: bp, cnt: 10'(m_cnt[k])};
  endtask

  // One tick of stimulus: optional reset pulse between edges (checked right
  // away), then drive inputs and queue the predicted post-edge outputs.
  task automatic applyStimulus(input bit do_rst, input bit se, input bit rn, input logic [4:0] btn);
    exp_t e0, e1;
    @(negedge CLK);
    if (do_rst) begin
      step_en = 1'b0;
      RST = 1'b1;
      #1;
      checkOutput("async_rst_dut0", RST_EXP, act0());
      checkOutput("async_rst_dut1", RST_EXP, act1());
      model_reset();
      #1;
      RST = 1'b0;
    end
    step_en    = se;
    run        = rn;
    {UPbtn, DOWNbtn, RIGHTbtn, LEFTbtn, CTRLbtn} = btn;
    mazestate  = s_maze;
    begin_spot = s_begin;
    goal_spot  = s_goal;
    model_tick(0, 0, 1023, e0);
    model_tick(1, 1, 15, e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  // Monitor: outputs are presented every edge, so compare once per edge
  // whenever a prediction is waiting.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (q0.size() > 0) checkOutput("tick_dut0", q0.pop_front(), act0());
      if (q1.size() > 0) checkOutput("tick_dut1", q1.pop_front(), act1());
    end
  end

  initial begin
    logic [4:0] btn;
    int guard;

    RST = 1'b1;
    #2;
    checkOutput("reset_dut0", RST_EXP, act0());
    checkOutput("reset_dut1", RST_EXP, act1());
    model_reset();
    RST = 1'b0;

    $display("[TB] directed sequence");
    s_maze = '1;
    applyStimulus(1, 1, 1, B_UP);
    applyStimulus(0, 0, 1, 5'b0);

    s_maze[182] = 1'b0;
    applyStimulus(1, 1, 1, B_RT);
    s_begin = 8'd19;
    applyStimulus(0, 1, 1, B_CT);

    s_maze[182] = 1'b1;
    s_goal = 8'd182;
    applyStimulus(1, 1, 1, B_RT);
    repeat (3) applyStimulus(0, 1, 1, B_RT);

    s_begin = 8'd17;
    applyStimulus(0, 1, 1, B_CT | B_LT);
    applyStimulus(0, 1, 1, B_RT);

    s_begin = 8'd250;
    applyStimulus(0, 1, 1, B_CT);
    s_maze[100] = 1'b0;
    s_begin = 8'd100;
    applyStimulus(0, 1, 1, B_CT);

    s_goal = 8'd197;
    applyStimulus(1, 0, 1, 5'b0);
    repeat (10) applyStimulus(0, 1, 0, B_UP | B_LT);
    applyStimulus(0, 1, 1, B_UP | B_LT);

    s_maze[145] = 1'b0;
    applyStimulus(0, 1, 1, B_UP);
    applyStimulus(1, 1, 1, 5'b0);

    $display("[TB] random sequence");
    for (int t = 0; t < 800; t++) begin
      if (t % 60 == 0) begin
        for (int i = 0; i < CELLS; i++)
          s_maze = {s_maze[CELLS-2:0], ($urandom_range(0, 3) != 0)};
        s_goal = 8'($urandom_range(0, CELLS - 1));
      end
      if ($urandom_range(0, 9) == 0) s_begin = 8'($urandom_range(0, 255));
      else                           s_begin = 8'($urandom_range(0, CELLS - 1));
      btn[4] = ($urandom_range(0, 4) == 0);
      btn[3] = ($urandom_range(0, 3) == 0);
      btn[2] = ($urandom_range(0, 2) == 0);
      btn[1] = ($urandom_range(0, 2) == 0);
      btn[0] = ($urandom_range(0, 3) == 0);
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) < 9, btn);
    end

    guard = 0;
    while ((q0.size() > 0 || q1.size() > 0) && guard < 20) begin
      @(posedge CLK);
      guard++;
    end
    #2;
    if (q0.size() > 0 || q1.size() > 0) begin
      n_miss++;
      $display("[TB] FAIL drain: got %0d/%0d pending predictions, expected 0", q0.size(), q1.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/maze_cursor_ctrl.md
MAZE_CURSOR_CTRL -- requirements
Module: maze_cursor_ctrl

Interface
REQ-001 The block SHALL have parameter MAZE_W, default 18, meaning maze columns.
REQ-002 The block SHALL have parameter MAZE_H, default 11, meaning maze rows.
REQ-003 The block SHALL have parameter POS_W, default 8, meaning position index width; it must satisfy 2^POS_W - 1 >= MAZE_W*MAZE_H.
REQ-004 The block SHALL have parameter START_POS, default 181, meaning position after reset.
REQ-005 The block SHALL have parameter WALL_MODE, default 0: 0 = a wall/edge hit crashes; 1 = a wall/edge hit blocks the move.
REQ-006 The block SHALL have parameter CNT_W, default 10, meaning move counter width.
REQ-007 Ports SHALL be as follows; single clock, reset asynchronous and active-high:
- CLK  in  1  system clock
- RST  in  1  async active-high reset
- step_en  in  1  one-CLK move tick (~5 Hz)
- run  in  1  1 = play, 0 = paused
- UPbtn, DOWNbtn, RIGHTbtn, LEFTbtn, CTRLbtn  in  1 each  level buttons
- mazestate  in  MAZE_W*MAZE_H  bit i = 1 is open cell i, 0 is wall
- begin_spot  in  POS_W  respawn cell
- goal_spot  in  POS_W  goal cell
- pos  out  POS_W  current cell; all-ones (SENTINEL) while crashed
- state  out  2  00 PLAY, 01 CRASH, 10 WIN
- moved  out  1  one-CLK pulse on each accepted move
- bumped  out  1  one-CLK pulse on each blocked move (WALL_MODE=1 only)
- move_count  out  CNT_W  accepted moves since last (re)spawn

Function
REQ-008 All state SHALL update only on rising CLK when step_en=1 and run=1; otherwise all registers SHALL hold and moved/bumped SHALL be 0.
REQ-009 Direction priority SHALL be UP > DOWN > RIGHT > LEFT; only one move SHALL be evaluated per tick.
REQ-010 Candidate cells SHALL be: UP pos-MAZE_W, DOWN pos+MAZE_W, RIGHT pos+1, LEFT pos-1.
REQ-011 A move SHALL be illegal if it leaves the grid: UP at row 0, DOWN at row MAZE_H-1, RIGHT at column MAZE_W-1, LEFT at column 0. Row/column wrap-around SHALL never occur.
REQ-012 A move SHALL be illegal if mazestate[candidate]=0.
REQ-013 In PLAY, a legal move SHALL set pos to the candidate, pulse moved, and increment move_count, saturating at all-ones.
REQ-014 In PLAY with an illegal move and WALL_MODE=0, pos SHALL become SENTINEL and state SHALL become CRASH; move_count SHALL hold.
REQ-015 In PLAY with an illegal move and WALL_MODE=1, pos SHALL hold and bumped SHALL pulse.
REQ-016 If an accepted move lands on goal_spot, state SHALL become WIN in the same tick, with pos equal to goal_spot.
REQ-017 In PLAY with no direction button, CTRLbtn SHALL have no effect.
REQ-018 In CRASH or WIN, direction buttons SHALL be ignored; CTRLbtn SHALL respawn: pos <= begin_spot, move_count <= 0, state <= PLAY.
REQ-019 If begin_spot is out of range or mazestate[begin_spot]=0 on respawn, state SHALL stay CRASH and pos SHALL stay SENTINEL.
REQ-020 If CTRLbtn and a direction button are pressed together in CRASH/WIN, respawn SHALL win and no move SHALL be made in that tick.
REQ-021 Wall lookup SHALL use the registered pos only, never a just-computed value.
REQ-022 State encoding 11 SHALL be unreachable; if reached, the next tick SHALL go to CRASH.

Reset
REQ-023 On RST=1, asynchronously: pos=START_POS, state=PLAY, move_count=0, moved=0, bumped=0.
REQ-024 If RST is asserted mid-tick or during CRASH/WIN, the reset values SHALL apply immediately; the first move after release SHALL need a new step_en.

Verification
REQ-025 Reset, mazestate[163]=1, UPbtn, one tick -> pos=163, moved=1 for 1 CLK, move_count=1.
REQ-026 pos=181, mazestate[182]=0, RIGHTbtn tick, WALL_MODE=0 -> pos=255, state=CRASH; then CTRLbtn tick with begin_spot=19 (open) -> pos=19, state=PLAY, move_count=0.
REQ-027 pos=17 (column 17), RIGHTbtn, mazestate[18]=1 -> crash (WALL_MODE=0), or pos=17 with bumped=1 (WALL_MODE=1); pos never 18.
REQ-028 UPbtn+LEFTbtn held, run=0 for 10 ticks -> pos unchanged; then run=1, one tick -> UP taken.
REQ-029 goal_spot=182, RIGHT from 181 open -> state=WIN, pos=182; further RIGHT ticks -> no change.
REQ-030 RST pulse asserted between CLK edges while in CRASH -> pos=181, state=PLAY before the next edge.
